// File: rtl/vnlp_pkg.sv
// Shared types and default widths for the VNLP averaging block.
package vnlp_pkg;

  localparam int unsigned SUM_W = 28;
  localparam int unsigned LEN_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StDiv,
    StHold
  } state_e;

endpackage

// File: rtl/vnlp_avg_if.sv
// Request, VNLP-stage handshake and result bundle for vnlp_avg.
interface vnlp_avg_if #(
  parameter int unsigned SUM_W = vnlp_pkg::SUM_W,
  parameter int unsigned LEN_W = vnlp_pkg::LEN_W
);

  logic             req;
  logic             vnlp_start;
  logic             vnlp_done;
  logic [SUM_W-1:0] vnlp_sum;
  logic [LEN_W-1:0] vnlp_len;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [LEN_W-1:0] res_len;
  logic [SUM_W-1:0] res_avg;
  logic [LEN_W-1:0] res_rem;
  logic             res_div0;
  logic             busy;

  // The averaging block itself
  modport slave (
    input  req, vnlp_done, vnlp_sum, vnlp_len, res_ready,
    output vnlp_start, res_valid, res_sum, res_len, res_avg, res_rem, res_div0, busy
  );

  // The environment: requester, VNLP stage and result consumer
  modport master (
    output req, vnlp_done, vnlp_sum, vnlp_len, res_ready,
    input  vnlp_start, res_valid, res_sum, res_len, res_avg, res_rem, res_div0, busy
  );

endinterface

// File: rtl/vnlp_seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, SUM_W cycles per load.
module vnlp_seq_div #(
  parameter int unsigned SUM_W = vnlp_pkg::SUM_W,
  parameter int unsigned LEN_W = vnlp_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SUM_W-1:0] dividend,
  input  logic [LEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient,
  output logic [LEN_W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] dvd_q, dvd_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LEN_W+1:0] shifted;
  logic [LEN_W+1:0] diff;
  logic             qbit;

  // Dividend register shifts left and collects quotient bits from the LSB end
  always_comb begin
    shifted = {rem_q, dvd_q[SUM_W-1]};
    diff    = shifted - (LEN_W + 2)'(divisor);
    qbit    = shifted >= (LEN_W + 2)'(divisor);
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (load) begin
      dvd_d = dividend;
      rem_d = '0;
      cnt_d = CntW'(SUM_W);
    end else if (busy) begin
      rem_d = qbit ? diff[LEN_W:0] : shifted[LEN_W:0];
      dvd_d = {dvd_q[SUM_W-2:0], qbit};
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CntW'(1);
  // Final-step results, valid while done is high
  assign quotient  = {dvd_q[SUM_W-2:0], qbit};
  assign remainder = rem_d[LEN_W-1:0];

endmodule

// File: rtl/vnlp_avg.sv
// Kicks one VNLP run per request, captures sum/len on a fresh done edge and holds floor(sum/len).
module vnlp_avg #(
  parameter int unsigned SUM_W = vnlp_pkg::SUM_W,
  parameter int unsigned LEN_W = vnlp_pkg::LEN_W
) (
  input logic       clk,
  input logic       rst_n,
  vnlp_avg_if.slave bus
);

  import vnlp_pkg::*;

  state_e           state_q, state_d;
  logic             done_prev_q;
  logic [SUM_W-1:0] res_sum_q, res_sum_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [SUM_W-1:0] res_avg_q, res_avg_d;
  logic [LEN_W-1:0] res_rem_q, res_rem_d;
  logic             res_div0_q, res_div0_d;
  logic             capture;
  logic             div_load;
  logic             div_busy;
  logic             div_done;
  logic [SUM_W-1:0] div_quot;
  logic [LEN_W-1:0] div_rem;

  // A done level carried over from an earlier run must fall before it can capture again
  assign capture  = (state_q == StWait) && bus.vnlp_done && !done_prev_q;
  assign div_load = capture && (bus.vnlp_len != '0);

  vnlp_seq_div #(
    .SUM_W(SUM_W),
    .LEN_W(LEN_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (bus.vnlp_sum),
    .divisor  (res_len_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot),
    .remainder(div_rem)
  );

  always_comb begin
    state_d    = state_q;
    res_sum_d  = res_sum_q;
    res_len_d  = res_len_q;
    res_avg_d  = res_avg_q;
    res_rem_d  = res_rem_q;
    res_div0_d = res_div0_q;
    unique case (state_q)
      StIdle:  if (bus.req) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (capture) begin
          res_sum_d  = bus.vnlp_sum;
          res_len_d  = bus.vnlp_len;
          res_avg_d  = '0;
          res_rem_d  = '0;
          res_div0_d = bus.vnlp_len == '0;
          state_d    = (bus.vnlp_len == '0) ? StHold : StDiv;
        end
      end
      StDiv: begin
        if (div_done) begin
          res_avg_d = div_quot;
          res_rem_d = div_rem;
          state_d   = StHold;
        end
      end
      StHold:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_prev_q <= 1'b0;
      res_sum_q   <= '0;
      res_len_q   <= '0;
      res_avg_q   <= '0;
      res_rem_q   <= '0;
      res_div0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= bus.vnlp_done;
      res_sum_q   <= res_sum_d;
      res_len_q   <= res_len_d;
      res_avg_q   <= res_avg_d;
      res_rem_q   <= res_rem_d;
      res_div0_q  <= res_div0_d;
    end
  end

  assign bus.vnlp_start = state_q == StStart;
  assign bus.res_valid  = state_q == StHold;
  assign bus.busy       = (state_q != StIdle) || div_busy;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_len    = res_len_q;
  assign bus.res_avg    = res_avg_q;
  assign bus.res_rem    = res_rem_q;
  assign bus.res_div0   = res_div0_q;

endmodule

// File: tb/tb_vnlp_avg.sv
// Scoreboard bench for vnlp_avg: expected results queued at stimulus, compared at handshake.
module tb_vnlp_avg;

  localparam int unsigned SW = vnlp_pkg::SUM_W;
  localparam int unsigned LW = vnlp_pkg::LEN_W;

  typedef struct {
    logic [SW-1:0] sum;
    logic [LW-1:0] len;
    logic [SW-1:0] avg;
    logic [LW-1:0] rem;
    logic          div0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  logic [SW-1:0] last_sum;

  vnlp_avg_if #(.SUM_W(SW), .LEN_W(LW)) bus ();

  vnlp_avg #(.SUM_W(SW), .LEN_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required run completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic [SW-1:0] s, input logic [LW-1:0] l, input int bp,
                        input bit stale, input bit keep_done, input bit req_mid);
    exp_t e;
    exp_t got;
    int   n;
    e.sum  = s;
    e.len  = l;
    e.div0 = (l == '0);
    e.avg  = (l == '0) ? '0 : SW'(64'(s) / 64'(l));
    e.rem  = (l == '0) ? '0 : LW'(64'(s) % 64'(l));
    sb.push_back(e);

    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    check("start_pulse", 64'(bus.vnlp_start), 64'd1);
    check("busy_start", 64'(bus.busy), 64'd1);
    step();
    check("start_one_cycle", 64'(bus.vnlp_start), 64'd0);

    bus.vnlp_sum = s;
    bus.vnlp_len = l;
    if (stale) begin
      repeat (4) step();
      check("stale_no_capture", 64'(bus.res_sum), 64'(last_sum));
      bus.vnlp_done = 1'b0;
      step();
    end
    bus.vnlp_done = 1'b1;
    step();
    check("cap_sum", 64'(bus.res_sum), 64'(s));
    check("cap_len", 64'(bus.res_len), 64'(l));

    n = 0;
    while (!bus.res_valid && n < 200) begin
      bus.req = req_mid && (n == 5);
      step();
      n++;
    end
    bus.req = 1'b0;
    check("latency", 64'(n), (l == '0) ? 64'd0 : 64'(SW));

    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_valid", 64'(bus.res_valid), 64'd1);
      check("bp_avg", 64'(bus.res_avg), 64'(e.avg));
    end

    if (!keep_done) bus.vnlp_done = 1'b0;
    bus.res_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check("res_valid", 64'(bus.res_valid), 64'd1);
      check("res_sum", 64'(bus.res_sum), 64'(got.sum));
      check("res_len", 64'(bus.res_len), 64'(got.len));
      check("res_avg", 64'(bus.res_avg), 64'(got.avg));
      check("res_rem", 64'(bus.res_rem), 64'(got.rem));
      check("res_div0", 64'(bus.res_div0), 64'(got.div0));
    end
    step();
    bus.res_ready = 1'b0;
    check("valid_drop", 64'(bus.res_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    if (req_mid) begin
      repeat (2) step();
      check("req_mid_ignored", 64'(bus.busy), 64'd0);
    end
    last_sum = s;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    last_sum      = '0;
    rst_n         = 1'b0;
    bus.req       = 1'b0;
    bus.vnlp_done = 1'b0;
    bus.vnlp_sum  = '0;
    bus.vnlp_len  = '0;
    bus.res_ready = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_start", 64'(bus.vnlp_start), 64'd0);
    check("rst_avg", 64'(bus.res_avg), 64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("no_run_without_req", 64'(bus.busy), 64'd0);

    do_run(28'd1000, 9'd8, 0, 1'b0, 1'b0, 1'b0);
    do_run(28'd100, 9'd7, 10, 1'b0, 1'b1, 1'b0);
    do_run(28'd55, 9'd0, 0, 1'b1, 1'b0, 1'b0);
    do_run(28'hFFFFFFF, 9'd1, 0, 1'b0, 1'b0, 1'b0);
    do_run(28'hFFFFFFF, 9'd511, 2, 1'b0, 1'b0, 1'b1);

    // Abort a division part way through with an asynchronous reset
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    bus.vnlp_sum  = 28'd77777;
    bus.vnlp_len  = 9'd13;
    bus.vnlp_done = 1'b1;
    step();
    repeat (12) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_sum", 64'(bus.res_sum), 64'd0);
    check("mid_rst_len", 64'(bus.res_len), 64'd0);
    check("mid_rst_start", 64'(bus.vnlp_start), 64'd0);
    bus.vnlp_done = 1'b0;
    step();
    rst_n    = 1'b1;
    last_sum = '0;
    repeat (3) step();
    check("post_rst_idle", 64'(bus.busy), 64'd0);
    do_run(28'd123456, 9'd100, 1, 1'b0, 1'b0, 1'b0);
    do_run(28'd5, 9'd9, 0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
